// File: rtl/reorder_buffer_pkg.sv
// Shared ROB types: tag type, NON_DEPENDENT tag, entry-type encodings, depth/width constants.
// Latency: n/a (types and pure helper functions only).
// Backpressure: n/a.
package reorder_buffer_pkg;

    localparam int ROB_DEPTH = 16;
    localparam int ROB_ID_W  = 5;
    localparam int XLEN      = 32;
    localparam int IDX_W     = $clog2(ROB_DEPTH);

    typedef logic [ROB_ID_W-1:0] ROB_ID_TYPE;
    typedef logic [IDX_W-1:0]    rob_idx_t;

    localparam ROB_ID_TYPE NON_DEPENDENT = '0;

    typedef enum logic [1:0] {
        TYPE_REG    = 2'd0,
        TYPE_BRANCH = 2'd1,
        TYPE_STORE  = 2'd2,
        TYPE_RSVD   = 2'd3
    } entry_type_t;

    typedef struct packed {
        logic            busy;
        logic            ready;
        entry_type_t     typ;
        logic [4:0]      rd;
        logic [XLEN-1:0] pc;
        logic            pred;
        logic [XLEN-1:0] value;
        logic            taken;
        logic [XLEN-1:0] target;
    } rob_entry_t;

    // Tags are 1-based: entry index i carries ID i+1; 0 and IDs past the depth never match.
    function automatic logic id_in_range(input ROB_ID_TYPE id);
        return (id != NON_DEPENDENT) && (id <= ROB_ID_TYPE'(ROB_DEPTH));
    endfunction

    function automatic rob_idx_t id_to_idx(input ROB_ID_TYPE id);
        ROB_ID_TYPE m1;
        m1 = id - ROB_ID_TYPE'(1);
        return m1[IDX_W-1:0];
    endfunction

    function automatic rob_idx_t ptr_inc(input rob_idx_t p);
        return (p == rob_idx_t'(ROB_DEPTH - 1)) ? '0 : p + rob_idx_t'(1);
    endfunction

endpackage

// File: rtl/reorder_buffer_if.sv
// ROB bus: dispatcher alloc, operand queries, CDB broadcast and commit/flush outputs.
// Latency: wires only.
// Backpressure: rob_full is the only stall; the dispatcher must hold alloc while it is set.
interface reorder_buffer_if;
    import reorder_buffer_pkg::*;

    logic             alloc_valid;
    logic [1:0]       alloc_type;
    logic [4:0]       alloc_rd;
    logic [XLEN-1:0]  alloc_pc;
    logic             alloc_pred_taken;
    ROB_ID_TYPE       alloc_id;
    logic             rob_full;

    ROB_ID_TYPE       query_id1;
    ROB_ID_TYPE       query_id2;
    logic             query_rdy1;
    logic             query_rdy2;
    logic [XLEN-1:0]  query_val1;
    logic [XLEN-1:0]  query_val2;

    logic             cdb_valid;
    ROB_ID_TYPE       cdb_id;
    logic [XLEN-1:0]  cdb_value;
    logic             cdb_taken;
    logic [XLEN-1:0]  cdb_target;

    logic             commit_reg_en;
    logic [4:0]       commit_rd;
    ROB_ID_TYPE       commit_id;
    logic [XLEN-1:0]  commit_value;
    logic             commit_store_en;
    logic             mispredict;
    logic [XLEN-1:0]  redirect_pc;

    modport master (
        output alloc_valid, alloc_type, alloc_rd, alloc_pc, alloc_pred_taken,
        output query_id1, query_id2,
        output cdb_valid, cdb_id, cdb_value, cdb_taken, cdb_target,
        input  alloc_id, rob_full, query_rdy1, query_rdy2, query_val1, query_val2,
        input  commit_reg_en, commit_rd, commit_id, commit_value, commit_store_en,
        input  mispredict, redirect_pc
    );

    modport slave (
        input  alloc_valid, alloc_type, alloc_rd, alloc_pc, alloc_pred_taken,
        input  query_id1, query_id2,
        input  cdb_valid, cdb_id, cdb_value, cdb_taken, cdb_target,
        output alloc_id, rob_full, query_rdy1, query_rdy2, query_val1, query_val2,
        output commit_reg_en, commit_rd, commit_id, commit_value, commit_store_en,
        output mispredict, redirect_pc
    );

endinterface

// File: rtl/reorder_buffer_query_port.sv
// Operand tag lookup into the ROB (module rob_query_port); NON_DEPENDENT never reports ready.
// Latency: combinational; with ROB_CDB_BYPASS_EN a same-cycle CDB hit is forwarded.
// Backpressure: none.
module rob_query_port
    import reorder_buffer_pkg::*;
(
    input  logic [ROB_DEPTH-1:0] busy,
    input  logic [ROB_DEPTH-1:0] ready,
    input  logic [XLEN-1:0]      value [ROB_DEPTH],
    input  ROB_ID_TYPE           query_id,
    input  logic                 cdb_valid,
    input  ROB_ID_TYPE           cdb_id,
    input  logic [XLEN-1:0]      cdb_value,
    output logic                 query_rdy,
    output logic [XLEN-1:0]      query_val
);

    rob_idx_t idx;
    logic     hit;

    always_comb begin
        idx       = id_to_idx(query_id);
        hit       = id_in_range(query_id) && busy[idx];
        query_rdy = hit && ready[idx];
        query_val = id_in_range(query_id) ? value[idx] : '0;
`ifdef ROB_CDB_BYPASS_EN
        if (hit && cdb_valid && (cdb_id == query_id)) begin
            query_rdy = 1'b1;
            query_val = cdb_value;
        end
`endif
    end

`ifndef ROB_CDB_BYPASS_EN
    logic unused_cdb;
    assign unused_cdb = ^{cdb_valid, cdb_id, cdb_value};
`endif

endmodule

// File: rtl/reorder_buffer.sv
// In-order retirement queue: alloc at tail, CDB marks done, one head retirement per cycle.
// Latency: commit outputs registered (edge after the entry is ready); ROB_CDB_BYPASS_EN adds query forwarding.
// Backpressure: rob_full refuses alloc; rdy=0 freezes all state; mispredict flushes and drops alloc/CDB for one cycle.
module reorder_buffer
    import reorder_buffer_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rdy,
    reorder_buffer_if.slave   rob
);

    rob_entry_t            ent [ROB_DEPTH];
    rob_idx_t              head;
    rob_idx_t              tail;
    logic [IDX_W:0]        count;

    logic [ROB_DEPTH-1:0]  busy_vec;
    logic [ROB_DEPTH-1:0]  ready_vec;
    logic [XLEN-1:0]       value_vec [ROB_DEPTH];

    rob_entry_t            hd;
    rob_idx_t              cdb_idx;
    logic                  do_alloc;
    logic                  do_commit;
    logic                  do_cdb;
    logic                  is_misp;

    always_comb begin
        for (int i = 0; i < ROB_DEPTH; i++) begin
            busy_vec[i]  = ent[i].busy;
            ready_vec[i] = ent[i].ready;
            value_vec[i] = ent[i].value;
        end
    end

    assign rob.rob_full = (count == (IDX_W+1)'(ROB_DEPTH));
    assign rob.alloc_id = ROB_ID_TYPE'(tail) + ROB_ID_TYPE'(1);

    // Readiness is the pre-edge value, so a CDB write to the head retires one cycle later.
    always_comb begin
        hd        = ent[head];
        cdb_idx   = id_to_idx(rob.cdb_id);
        do_alloc  = rdy && rob.alloc_valid && !rob.rob_full && !rob.mispredict;
        do_commit = rdy && hd.busy && hd.ready;
        do_cdb    = rdy && rob.cdb_valid && !rob.mispredict &&
                    id_in_range(rob.cdb_id) && ent[cdb_idx].busy;
        is_misp   = do_commit && (hd.typ == TYPE_BRANCH) && (hd.taken != hd.pred);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < ROB_DEPTH; i++) ent[i] <= '0;
            head                <= '0;
            tail                <= '0;
            count               <= '0;
            rob.commit_reg_en   <= 1'b0;
            rob.commit_rd       <= '0;
            rob.commit_id       <= '0;
            rob.commit_value    <= '0;
            rob.commit_store_en <= 1'b0;
            rob.mispredict      <= 1'b0;
            rob.redirect_pc     <= '0;
        end else if (rdy) begin
            rob.commit_reg_en   <= 1'b0;
            rob.commit_store_en <= 1'b0;
            rob.mispredict      <= 1'b0;

            if (do_cdb) begin
                ent[cdb_idx].ready  <= 1'b1;
                ent[cdb_idx].value  <= rob.cdb_value;
                ent[cdb_idx].taken  <= rob.cdb_taken;
                ent[cdb_idx].target <= rob.cdb_target;
            end

            if (do_alloc) begin
                ent[tail].busy   <= 1'b1;
                ent[tail].ready  <= 1'b0;
                ent[tail].typ    <= entry_type_t'(rob.alloc_type);
                ent[tail].rd     <= rob.alloc_rd;
                ent[tail].pc     <= rob.alloc_pc;
                ent[tail].pred   <= rob.alloc_pred_taken;
                tail             <= ptr_inc(tail);
            end

            if (do_commit) begin
                ent[head].busy   <= 1'b0;
                head             <= ptr_inc(head);
                rob.commit_id    <= ROB_ID_TYPE'(head) + ROB_ID_TYPE'(1);
                rob.commit_rd    <= hd.rd;
                rob.commit_value <= hd.value;
                if (hd.typ == TYPE_STORE)
                    rob.commit_store_en <= 1'b1;
                else if (hd.typ != TYPE_BRANCH)
                    rob.commit_reg_en <= (hd.rd != 5'd0);
            end

            count <= count + (IDX_W+1)'(do_alloc) - (IDX_W+1)'(do_commit);

            // Flush wins over everything above, including a same-cycle younger alloc.
            if (is_misp) begin
                for (int i = 0; i < ROB_DEPTH; i++) begin
                    ent[i].busy  <= 1'b0;
                    ent[i].ready <= 1'b0;
                end
                head            <= '0;
                tail            <= '0;
                count           <= '0;
                rob.mispredict  <= 1'b1;
                rob.redirect_pc <= hd.taken ? hd.target : hd.pc + XLEN'(4);
            end
        end
    end

    rob_query_port u_query1 (
        .busy      (busy_vec),
        .ready     (ready_vec),
        .value     (value_vec),
        .query_id  (rob.query_id1),
        .cdb_valid (rob.cdb_valid),
        .cdb_id    (rob.cdb_id),
        .cdb_value (rob.cdb_value),
        .query_rdy (rob.query_rdy1),
        .query_val (rob.query_val1)
    );

    rob_query_port u_query2 (
        .busy      (busy_vec),
        .ready     (ready_vec),
        .value     (value_vec),
        .query_id  (rob.query_id2),
        .cdb_valid (rob.cdb_valid),
        .cdb_id    (rob.cdb_id),
        .cdb_value (rob.cdb_value),
        .query_rdy (rob.query_rdy2),
        .query_val (rob.query_val2)
    );

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: reset, commit, full/wrap, mispredict flush, OOO CDB, freeze, query.
module tb_reorder_buffer;
    import reorder_buffer_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    logic rdy;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    reorder_buffer_if rob_bus ();

    reorder_buffer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rdy   (rdy),
        .rob   (rob_bus)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        rob_bus.alloc_valid      = 1'b0;
        rob_bus.alloc_type       = 2'd0;
        rob_bus.alloc_rd         = 5'd0;
        rob_bus.alloc_pc         = '0;
        rob_bus.alloc_pred_taken = 1'b0;
        rob_bus.query_id1        = '0;
        rob_bus.query_id2        = '0;
        rob_bus.cdb_valid        = 1'b0;
        rob_bus.cdb_id           = '0;
        rob_bus.cdb_value        = '0;
        rob_bus.cdb_taken        = 1'b0;
        rob_bus.cdb_target       = '0;
    endtask

    task automatic set_alloc(input logic [1:0] typ, input logic [4:0] rd,
                             input logic [31:0] pc, input logic pred);
        rob_bus.alloc_valid      = 1'b1;
        rob_bus.alloc_type       = typ;
        rob_bus.alloc_rd         = rd;
        rob_bus.alloc_pc         = pc;
        rob_bus.alloc_pred_taken = pred;
    endtask

    task automatic set_cdb(input logic [4:0] id, input logic [31:0] val,
                           input logic taken, input logic [31:0] tgt);
        rob_bus.cdb_valid  = 1'b1;
        rob_bus.cdb_id     = id;
        rob_bus.cdb_value  = val;
        rob_bus.cdb_taken  = taken;
        rob_bus.cdb_target = tgt;
    endtask

    task automatic do_reset();
        clear_inputs();
        rdy   = 1'b1;
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        check("rst_reg_en",   rob_bus.commit_reg_en,   0);
        check("rst_rd",       rob_bus.commit_rd,       0);
        check("rst_id",       rob_bus.commit_id,       0);
        check("rst_value",    rob_bus.commit_value,    0);
        check("rst_store_en", rob_bus.commit_store_en, 0);
        check("rst_misp",     rob_bus.mispredict,      0);
        check("rst_redirect", rob_bus.redirect_pc,     0);
        check("rst_alloc_id", rob_bus.alloc_id,        1);
        check("rst_full",     rob_bus.rob_full,        0);
    endtask

    initial begin
        // Basic REG commit latency
        do_reset();
        set_alloc(2'd0, 5'd5, 32'h40, 1'b0);
        step();
        clear_inputs();
        set_cdb(5'd1, 32'hDEAD_BEEF, 1'b0, 32'h0);
        step();
        clear_inputs();
        step();
        check("reg_en",    rob_bus.commit_reg_en, 1);
        check("reg_rd",    rob_bus.commit_rd,     5);
        check("reg_id",    rob_bus.commit_id,     1);
        check("reg_value", rob_bus.commit_value,  32'hDEAD_BEEF);
        step();
        check("reg_en_pulse", rob_bus.commit_reg_en, 0);

        // Fill, overflow refusal, pointer wrap
        do_reset();
        for (int i = 0; i < 16; i++) begin
            set_alloc(2'd0, 5'(i + 1), 32'(i * 4), 1'b0);
            step();
        end
        clear_inputs();
        check("fill_full",     rob_bus.rob_full, 1);
        check("fill_alloc_id", rob_bus.alloc_id, 1);
        set_alloc(2'd0, 5'd31, 32'h0, 1'b0);
        step();
        clear_inputs();
        check("ovf_full",     rob_bus.rob_full,      1);
        check("ovf_alloc_id", rob_bus.alloc_id,      1);
        check("ovf_reg_en",   rob_bus.commit_reg_en, 0);
        set_cdb(5'd1, 32'h11, 1'b0, 32'h0);
        step();
        clear_inputs();
        set_alloc(2'd0, 5'd31, 32'h0, 1'b0);
        step();
        clear_inputs();
        check("fullc_full",     rob_bus.rob_full,  0);
        check("fullc_alloc_id", rob_bus.alloc_id,  1);
        check("fullc_id",       rob_bus.commit_id, 1);
        check("fullc_rd",       rob_bus.commit_rd, 1);
        set_alloc(2'd0, 5'd9, 32'h0, 1'b0);
        set_cdb(5'd2, 32'h22, 1'b0, 32'h0);
        step();
        clear_inputs();
        check("wrap_full",     rob_bus.rob_full,      1);
        check("wrap_alloc_id", rob_bus.alloc_id,      2);
        check("wrap_reg_en",   rob_bus.commit_reg_en, 0);
        step();
        check("c2_id",     rob_bus.commit_id,     2);
        check("c2_reg_en", rob_bus.commit_reg_en, 1);
        check("c2_full",   rob_bus.rob_full,      0);
        set_cdb(5'd3, 32'h33, 1'b0, 32'h0);
        step();
        clear_inputs();
        check("d_reg_en", rob_bus.commit_reg_en, 0);
        set_alloc(2'd0, 5'd9, 32'h0, 1'b0);
        step();
        clear_inputs();
        check("ac_id",       rob_bus.commit_id, 3);
        check("ac_full",     rob_bus.rob_full,  0);
        check("ac_alloc_id", rob_bus.alloc_id,  3);
        set_alloc(2'd0, 5'd9, 32'h0, 1'b0);
        step();
        clear_inputs();
        check("ac_refill_full", rob_bus.rob_full, 1);

        // Branch mispredict flush (taken path), then not-taken path
        do_reset();
        set_alloc(2'd1, 5'd0, 32'h100, 1'b0);
        step();
        for (int i = 0; i < 3; i++) begin
            set_alloc(2'd0, 5'(10 + i), 32'h104 + 32'(i * 4), 1'b0);
            step();
        end
        clear_inputs();
        for (int i = 0; i < 3; i++) begin
            set_cdb(5'(2 + i), 32'hA0 + 32'(i), 1'b0, 32'h0);
            step();
        end
        set_cdb(5'd1, 32'h0, 1'b1, 32'h200);
        step();
        clear_inputs();
        step();
        check("mp_pulse",    rob_bus.mispredict,    1);
        check("mp_redirect", rob_bus.redirect_pc,   32'h200);
        check("mp_alloc_id", rob_bus.alloc_id,      1);
        check("mp_full",     rob_bus.rob_full,      0);
        check("mp_reg_en",   rob_bus.commit_reg_en, 0);
        set_alloc(2'd0, 5'd13, 32'h0, 1'b0);
        set_cdb(5'd1, 32'h55, 1'b0, 32'h0);
        step();
        clear_inputs();
        check("mp_deassert",    rob_bus.mispredict, 0);
        check("mp_alloc_ignor", rob_bus.alloc_id,   1);
        for (int i = 0; i < 2; i++) begin
            step();
            check("mp_no_young", rob_bus.commit_reg_en, 0);
        end
        set_alloc(2'd1, 5'd0, 32'h300, 1'b1);
        step();
        clear_inputs();
        set_cdb(5'd1, 32'h0, 1'b0, 32'h500);
        step();
        clear_inputs();
        step();
        check("mp_nt_pulse",    rob_bus.mispredict,  1);
        check("mp_nt_redirect", rob_bus.redirect_pc, 32'h304);

        // Out-of-order CDB, rd=0, store, freeze, query ports
        do_reset();
        set_alloc(2'd0, 5'd3, 32'h0, 1'b0);
        step();
        set_alloc(2'd0, 5'd0, 32'h4, 1'b0);
        step();
        set_alloc(2'd2, 5'd0, 32'h8, 1'b0);
        step();
        clear_inputs();
        set_cdb(5'd2, 32'h2, 1'b0, 32'h0);
        step();
        clear_inputs();
        rob_bus.query_id1 = 5'd2;
        rob_bus.query_id2 = 5'd1;
        #1;
        check("q_rdy_done",  rob_bus.query_rdy1, 1);
        check("q_val_done",  rob_bus.query_val1, 2);
        check("q_rdy_wait",  rob_bus.query_rdy2, 0);
        check("ooo_no_early", rob_bus.commit_reg_en, 0);
        rob_bus.query_id2 = 5'd0;
        #1;
        check("q_rdy_nondep", rob_bus.query_rdy2, 0);
        set_cdb(5'd1, 32'h1, 1'b0, 32'h0);
        step();
        set_cdb(5'd3, 32'h3, 1'b0, 32'h0);
        rob_bus.query_id1 = 5'd3;
        #1;
`ifdef ROB_CDB_BYPASS_EN
        check("q_bypass_rdy", rob_bus.query_rdy1, 1);
        check("q_bypass_val", rob_bus.query_val1, 3);
`else
        check("q_nobypass_rdy", rob_bus.query_rdy1, 0);
`endif
        step();
        rob_bus.cdb_valid = 1'b0;
        #1;
        check("ooo_c1_id",    rob_bus.commit_id,     1);
        check("ooo_c1_en",    rob_bus.commit_reg_en, 1);
        check("ooo_c1_rd",    rob_bus.commit_rd,     3);
        check("ooo_c1_value", rob_bus.commit_value,  1);
        check("q_latched_rdy", rob_bus.query_rdy1,   1);
        check("q_latched_val", rob_bus.query_val1,   3);
        rdy = 1'b0;
        step();
        check("frz_reg_en", rob_bus.commit_reg_en, 1);
        check("frz_id",     rob_bus.commit_id,     1);
        rdy = 1'b1;
        step();
        check("ooo_c2_id",    rob_bus.commit_id,       2);
        check("ooo_rd0_en",   rob_bus.commit_reg_en,   0);
        check("ooo_c2_store", rob_bus.commit_store_en, 0);
        step();
        check("ooo_c3_id",    rob_bus.commit_id,       3);
        check("ooo_c3_store", rob_bus.commit_store_en, 1);
        check("ooo_c3_reg",   rob_bus.commit_reg_en,   0);
        step();
        check("store_pulse",  rob_bus.commit_store_en, 0);

        // Reset taken while busy
        set_alloc(2'd0, 5'd7, 32'h0, 1'b0);
        step();
        clear_inputs();
        do_reset();

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
